// File: rtl/eflags_unit.sv
// eflags_unit: EFLAGS register with prioritised update sources (interrupt save,
// IRET restore, POPF-style write, single-bit ops, ALU status) and a small
// save/restore stack used on interrupt entry and return.
module eflags_unit #(
    parameter int               WIDTH           = 32,
    parameter int               DEPTH           = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE     = 32'h0000_0002,
    parameter logic [WIDTH-1:0] WRITABLE_MASK   = 32'h0003_7FD5,
    parameter logic [WIDTH-1:0] SAVE_CLEAR_MASK = 32'h0003_4300
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         save_valid,
    input  logic                         restore_valid,
    input  logic                         write_valid,
    input  logic [WIDTH-1:0]             write_data,
    input  logic [1:0]                   cpl,
    input  logic                         bit_valid,
    input  logic [1:0]                   bit_op,
    input  logic [4:0]                   bit_index,
    input  logic                         alu_valid,
    input  logic [WIDTH-1:0]             alu_mask,
    input  logic [WIDTH-1:0]             alu_data,
    output logic [WIDTH-1:0]             EFLAGS,
    output logic [15:0]                  FLAGS,
    output logic                         CF,
    output logic                         PF,
    output logic                         AF,
    output logic                         ZF,
    output logic                         SF,
    output logic                         TF,
    output logic                         IF,
    output logic                         DF,
    output logic                         OF,
    output logic [1:0]                   IOPL,
    output logic                         NT,
    output logic                         RF,
    output logic                         VM,
    output logic                         stack_empty,
    output logic                         stack_full,
    output logic [$clog2(DEPTH+1)-1:0]   stack_level,
    output logic                         overflow_err,
    output logic                         underflow_err,
    output logic                         collision_err
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WIDTH-1:0] ALU_STATUS_MASK = WIDTH'(32'h0000_08D5);

    logic [WIDTH-1:0] eflags_q;
    logic [LW-1:0]    level_q;
    logic [WIDTH-1:0] stack_mem [0:(1<<IW)-1];

    logic [WIDTH-1:0] eflags_next;
    logic [LW-1:0]    level_next;
    logic             push;
    logic             overflow_next;
    logic             underflow_next;
    logic             collision_next;
    logic [WIDTH-1:0] write_value;
    logic [WIDTH-1:0] bit_onehot;
    logic [WIDTH-1:0] alu_sel;
    logic [2:0]       request_count;
    logic [IW-1:0]    wr_idx;
    logic [IW-1:0]    rd_idx;

    // Reserved bits always carry their reset value, whatever the source of an update.
    function automatic logic [WIDTH-1:0] legalize(input logic [WIDTH-1:0] v);
        return (v & WRITABLE_MASK) | (RESET_VALUE & ~WRITABLE_MASK);
    endfunction

    assign stack_full  = (level_q == LW'(DEPTH));
    assign stack_empty = (level_q == '0);
    assign wr_idx      = IW'(level_q);
    assign rd_idx      = IW'(level_q - LW'(1));

    // Compute the single accepted update for this cycle; lower-priority requests are dropped.
    always_comb begin
        eflags_next    = eflags_q;
        level_next     = level_q;
        push           = 1'b0;
        overflow_next  = 1'b0;
        underflow_next = 1'b0;
        write_value    = write_data;
        bit_onehot     = {{(WIDTH-1){1'b0}}, 1'b1} << bit_index;
        alu_sel        = alu_mask & ALU_STATUS_MASK;
        request_count  = 3'(save_valid) + 3'(restore_valid) + 3'(write_valid)
                       + 3'(bit_valid) + 3'(alu_valid);
        collision_next = (request_count > 3'd1);

        // POPF protection: VM is never writable, RF always clears, IOPL needs ring 0,
        // and IF needs cpl no higher than the current IOPL.
        write_value[17] = eflags_q[17];
        write_value[16] = 1'b0;
        if (cpl != 2'd0) begin
            write_value[13:12] = eflags_q[13:12];
        end
        if (cpl > eflags_q[13:12]) begin
            write_value[9] = eflags_q[9];
        end

        if (save_valid) begin
            if (stack_full) begin
                overflow_next = 1'b1;
            end else begin
                push        = 1'b1;
                level_next  = level_q + LW'(1);
                eflags_next = legalize(eflags_q & ~SAVE_CLEAR_MASK);
            end
        end else if (restore_valid) begin
            if (stack_empty) begin
                underflow_next = 1'b1;
            end else begin
                level_next  = level_q - LW'(1);
                eflags_next = legalize(stack_mem[rd_idx]);
            end
        end else if (write_valid) begin
            eflags_next = legalize(write_value);
        end else if (bit_valid) begin
            if ((bit_onehot & WRITABLE_MASK) != '0) begin
                case (bit_op)
                    2'b00:   eflags_next = legalize(eflags_q & ~bit_onehot);
                    2'b01:   eflags_next = legalize(eflags_q | bit_onehot);
                    2'b10:   eflags_next = legalize(eflags_q ^ bit_onehot);
                    default: eflags_next = eflags_q;
                endcase
            end
        end else if (alu_valid) begin
            eflags_next = legalize((eflags_q & ~alu_sel) | (alu_data & alu_sel));
        end
    end

    // Register state and one-cycle error pulses; reset empties the stack.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            eflags_q      <= RESET_VALUE;
            level_q       <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
            collision_err <= 1'b0;
        end else begin
            eflags_q      <= eflags_next;
            level_q       <= level_next;
            overflow_err  <= overflow_next;
            underflow_err <= underflow_next;
            collision_err <= collision_next;
        end
    end

    // Stack storage holds no reset; entries above the level are never read.
    always_ff @(posedge clock) begin
        if (push) begin
            stack_mem[wr_idx] <= eflags_q;
        end
    end

    assign EFLAGS      = eflags_q;
    assign FLAGS       = eflags_q[15:0];
    assign CF          = eflags_q[0];
    assign PF          = eflags_q[2];
    assign AF          = eflags_q[4];
    assign ZF          = eflags_q[6];
    assign SF          = eflags_q[7];
    assign TF          = eflags_q[8];
    assign IF          = eflags_q[9];
    assign DF          = eflags_q[10];
    assign OF          = eflags_q[11];
    assign IOPL        = eflags_q[13:12];
    assign NT          = eflags_q[14];
    assign RF          = eflags_q[16];
    assign VM          = eflags_q[17];
    assign stack_level = level_q;

endmodule

// File: tb/tb_eflags_unit.sv
// tb_eflags_unit: scoreboard bench for eflags_unit. Every driven request pushes the
// expected register/stack/error state, which is popped and compared one cycle later.
module tb_eflags_unit;

    localparam logic [31:0] WM  = 32'h0003_7FD5;
    localparam logic [31:0] RV  = 32'h0000_0002;
    localparam logic [31:0] SCM = 32'h0003_4300;

    logic        clock = 1'b0;
    logic        reset;
    logic        save_valid, restore_valid, write_valid, bit_valid, alu_valid;
    logic [31:0] write_data, alu_mask, alu_data;
    logic [1:0]  cpl, bit_op;
    logic [4:0]  bit_index;
    logic [31:0] eflags;
    logic [15:0] flags;
    logic        cf, pf, af, zf, sf, tf, if_flag, df, of_flag, nt, rf, vm;
    logic [1:0]  iopl;
    logic        stack_empty, stack_full, overflow_err, underflow_err, collision_err;
    logic [2:0]  stack_level;

    eflags_unit dut (
        .clock(clock), .reset(reset),
        .save_valid(save_valid), .restore_valid(restore_valid),
        .write_valid(write_valid), .write_data(write_data), .cpl(cpl),
        .bit_valid(bit_valid), .bit_op(bit_op), .bit_index(bit_index),
        .alu_valid(alu_valid), .alu_mask(alu_mask), .alu_data(alu_data),
        .EFLAGS(eflags), .FLAGS(flags),
        .CF(cf), .PF(pf), .AF(af), .ZF(zf), .SF(sf), .TF(tf), .IF(if_flag),
        .DF(df), .OF(of_flag), .IOPL(iopl), .NT(nt), .RF(rf), .VM(vm),
        .stack_empty(stack_empty), .stack_full(stack_full), .stack_level(stack_level),
        .overflow_err(overflow_err), .underflow_err(underflow_err),
        .collision_err(collision_err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        sv; logic rv; logic wv; logic [31:0] wd; logic [1:0] cp;
        logic        bv; logic [1:0] bop; logic [4:0] bi;
        logic        av; logic [31:0] am; logic [31:0] ad;
    } op_t;

    typedef struct packed {
        logic [31:0] ef; logic [2:0] lvl; logic ov; logic un; logic co;
    } exp_t;

    int          checks = 0;
    int          passes = 0;
    exp_t        sb[$];
    logic [31:0] m_ef;
    logic [31:0] m_stack[$];

    function automatic logic [31:0] legal(input logic [31:0] v);
        return (v & WM) | (RV & ~WM);
    endfunction

    function automatic op_t o_save();
        op_t o = '0; o.sv = 1'b1; return o;
    endfunction
    function automatic op_t o_restore();
        op_t o = '0; o.rv = 1'b1; return o;
    endfunction
    function automatic op_t o_write(input logic [31:0] d, input logic [1:0] c);
        op_t o = '0; o.wv = 1'b1; o.wd = d; o.cp = c; return o;
    endfunction
    function automatic op_t o_bit(input logic [1:0] op, input logic [4:0] idx);
        op_t o = '0; o.bv = 1'b1; o.bop = op; o.bi = idx; return o;
    endfunction
    function automatic op_t o_alu(input logic [31:0] m, input logic [31:0] d);
        op_t o = '0; o.av = 1'b1; o.am = m; o.ad = d; return o;
    endfunction

    // Drive one request for one cycle and record what the register should become.
    task automatic applyStimulus(input op_t o);
        exp_t        e;
        logic [31:0] n, mm, wm;
        int          nreq;
        wm            = WM;
        save_valid    = o.sv;  restore_valid = o.rv;
        write_valid   = o.wv;  write_data    = o.wd;  cpl = o.cp;
        bit_valid     = o.bv;  bit_op        = o.bop; bit_index = o.bi;
        alu_valid     = o.av;  alu_mask      = o.am;  alu_data  = o.ad;
        nreq = int'(o.sv) + int'(o.rv) + int'(o.wv) + int'(o.bv) + int'(o.av);
        e    = '0;
        e.co = (nreq > 1);
        if (o.sv) begin
            if (m_stack.size() == 4) e.ov = 1'b1;
            else begin
                m_stack.push_back(m_ef);
                m_ef = legal(m_ef & ~SCM);
            end
        end else if (o.rv) begin
            if (m_stack.size() == 0) e.un = 1'b1;
            else m_ef = m_stack.pop_back();
        end else if (o.wv) begin
            n = o.wd;
            n[17] = m_ef[17];
            n[16] = 1'b0;
            if (o.cp != 2'd0) n[13:12] = m_ef[13:12];
            if (o.cp > m_ef[13:12]) n[9] = m_ef[9];
            m_ef = legal(n);
        end else if (o.bv) begin
            if (o.bop != 2'b11 && wm[o.bi]) begin
                case (o.bop)
                    2'b00:   m_ef[o.bi] = 1'b0;
                    2'b01:   m_ef[o.bi] = 1'b1;
                    default: m_ef[o.bi] = ~m_ef[o.bi];
                endcase
            end
        end else if (o.av) begin
            mm   = o.am & 32'h0000_08D5;
            m_ef = (m_ef & ~mm) | (o.ad & mm);
        end
        e.ef  = m_ef;
        e.lvl = 3'(m_stack.size());
        sb.push_back(e);
        @(posedge clock);
        #1;
        save_valid = 1'b0; restore_valid = 1'b0; write_valid = 1'b0;
        bit_valid  = 1'b0; alu_valid     = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        save_valid = 1'b0; restore_valid = 1'b0; write_valid = 1'b0;
        bit_valid = 1'b0; alu_valid = 1'b0;
        write_data = '0; cpl = '0; bit_op = '0; bit_index = '0; alu_mask = '0; alu_data = '0;
        m_ef = RV;
        m_stack.delete();
        sb.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Reset state must be the documented reset value with an empty stack.
    task automatic test_reset();
        do_reset();
        checks++;
        if ({eflags, stack_empty, stack_full, stack_level, overflow_err, underflow_err, collision_err}
            !== {32'h2, 1'b1, 1'b0, 3'd0, 3'b000})
            $display("[TB] FAIL reset: got ef=%h empty=%b full=%b lvl=%0d err=%b%b%b, expected ef=00000002 empty=1 full=0 lvl=0 err=000",
                     eflags, stack_empty, stack_full, stack_level, overflow_err, underflow_err, collision_err);
        else passes++;
    endtask

    // ALU updates may only touch the six status flags.
    task automatic test_alu();
        op_t  ops[$];
        exp_t e;
        do_reset();
        ops = '{o_alu(32'hFFFF_FFFF, 32'hFFFF_FFFF), o_alu(32'h0000_0041, 32'h0),
                o_alu(32'h0000_0800, 32'h0)};
        foreach (ops[i]) begin
            applyStimulus(ops[i]);
            e = sb.pop_front();
            checks++;
            if ({eflags, stack_level, overflow_err, underflow_err, collision_err} !== {e.ef, e.lvl, e.ov, e.un, e.co})
                $display("[TB] FAIL alu op%0d: got ef=%h lvl=%0d err=%b%b%b, expected ef=%h lvl=%0d err=%b%b%b",
                         i, eflags, stack_level, overflow_err, underflow_err, collision_err, e.ef, e.lvl, e.ov, e.un, e.co);
            else passes++;
            if (i == 0) begin
                checks++;
                if ({eflags, flags, cf, pf, af, zf, sf, of_flag, tf, df} !== {32'h0000_08D7, 16'h08D7, 6'b111111, 2'b00})
                    $display("[TB] FAIL alu_all_ones: got ef=%h flags=%h, expected ef=000008d7 flags=08d7", eflags, flags);
                else passes++;
            end
        end
    endtask

    // POPF-style writes honour cpl/IOPL protection.
    task automatic test_write();
        op_t  ops[$];
        exp_t e;
        do_reset();
        ops = '{o_write(32'h0003_3200, 2'd3), o_write(32'h0003_FFFF, 2'd0),
                o_write(32'h0000_0000, 2'd3), o_write(32'h0000_1000, 2'd2),
                o_write(32'h0003_0000, 2'd0)};
        foreach (ops[i]) begin
            applyStimulus(ops[i]);
            e = sb.pop_front();
            checks++;
            if ({eflags, stack_level, overflow_err, underflow_err, collision_err} !== {e.ef, e.lvl, e.ov, e.un, e.co})
                $display("[TB] FAIL write op%0d: got ef=%h lvl=%0d err=%b%b%b, expected ef=%h lvl=%0d err=%b%b%b",
                         i, eflags, stack_level, overflow_err, underflow_err, collision_err, e.ef, e.lvl, e.ov, e.un, e.co);
            else passes++;
            if (i == 0) begin
                checks++;
                if (eflags !== 32'h2)
                    $display("[TB] FAIL write_protected: got ef=%h, expected ef=00000002", eflags);
                else passes++;
            end
            if (i == 1) begin
                checks++;
                if ({eflags, iopl, if_flag, rf, vm} !== {32'h0000_7FD7, 2'd3, 1'b1, 1'b0, 1'b0})
                    $display("[TB] FAIL write_ring0: got ef=%h, expected ef=00007fd7", eflags);
                else passes++;
            end
        end
    endtask

    // Single-bit ops act only on implemented bits; op 11 is a no-op.
    task automatic test_bit();
        op_t  ops[$];
        exp_t e;
        do_reset();
        ops = '{o_bit(2'b01, 5'd0), o_bit(2'b10, 5'd2), o_bit(2'b01, 5'd1), o_bit(2'b11, 5'd6),
                o_bit(2'b01, 5'd10), o_bit(2'b01, 5'd31), o_bit(2'b00, 5'd0), o_bit(2'b10, 5'd2),
                o_bit(2'b01, 5'd15), o_bit(2'b01, 5'd9)};
        foreach (ops[i]) begin
            applyStimulus(ops[i]);
            e = sb.pop_front();
            checks++;
            if ({eflags, stack_level, overflow_err, underflow_err, collision_err} !== {e.ef, e.lvl, e.ov, e.un, e.co})
                $display("[TB] FAIL bit op%0d: got ef=%h lvl=%0d err=%b%b%b, expected ef=%h lvl=%0d err=%b%b%b",
                         i, eflags, stack_level, overflow_err, underflow_err, collision_err, e.ef, e.lvl, e.ov, e.un, e.co);
            else passes++;
        end
        checks++;
        if (eflags !== 32'h0000_0602)
            $display("[TB] FAIL bit_final: got ef=%h, expected ef=00000602", eflags);
        else passes++;
    endtask

    // Fill, overflow, drain and underflow the stack, then check ordering with distinct entries.
    task automatic test_stack();
        op_t  ops[$];
        exp_t e;
        do_reset();
        ops = '{o_write(32'h0000_0302, 2'd0), o_save(), o_save(), o_save(), o_save(), o_save(),
                o_restore(), o_restore(), o_restore(), o_restore(), o_restore(),
                o_bit(2'b01, 5'd0), o_save(), o_bit(2'b01, 5'd6), o_save(), o_bit(2'b01, 5'd7),
                o_restore(), o_restore()};
        foreach (ops[i]) begin
            applyStimulus(ops[i]);
            e = sb.pop_front();
            checks++;
            if ({eflags, stack_level, overflow_err, underflow_err, collision_err} !== {e.ef, e.lvl, e.ov, e.un, e.co})
                $display("[TB] FAIL stack op%0d: got ef=%h lvl=%0d err=%b%b%b, expected ef=%h lvl=%0d err=%b%b%b",
                         i, eflags, stack_level, overflow_err, underflow_err, collision_err, e.ef, e.lvl, e.ov, e.un, e.co);
            else passes++;
            if (i == 4) begin
                checks++;
                if ({stack_full, tf, if_flag} !== 3'b100)
                    $display("[TB] FAIL stack_full: got full=%b tf=%b if=%b, expected full=1 tf=0 if=0", stack_full, tf, if_flag);
                else passes++;
            end
            if (i == 5) begin
                checks++;
                if ({overflow_err, eflags} !== {1'b1, 32'h2})
                    $display("[TB] FAIL stack_overflow: got ov=%b ef=%h, expected ov=1 ef=00000002", overflow_err, eflags);
                else passes++;
            end
            if (i == 9) begin
                checks++;
                if ({stack_empty, eflags} !== {1'b1, 32'h302})
                    $display("[TB] FAIL stack_drained: got empty=%b ef=%h, expected empty=1 ef=00000302", stack_empty, eflags);
                else passes++;
            end
            if (i == 10) begin
                checks++;
                if ({underflow_err, eflags} !== {1'b1, 32'h302})
                    $display("[TB] FAIL stack_underflow: got un=%b ef=%h, expected un=1 ef=00000302", underflow_err, eflags);
                else passes++;
            end
        end
    endtask

    // Simultaneous requests: only the highest priority acts and collision_err pulses.
    task automatic test_collision();
        op_t  ops[$];
        op_t  o;
        exp_t e;
        do_reset();
        o = o_bit(2'b01, 5'd0); o.av = 1'b1; o.am = 32'h40; o.ad = 32'h40;
        ops.push_back(o);
        o = o_save(); o.rv = 1'b1;
        ops.push_back(o);
        ops.push_back(o_alu(32'h0, 32'h0));
        o = o_write(32'h0, 2'd0); o.bv = 1'b1; o.bop = 2'b01; o.bi = 5'd11;
        ops.push_back(o);
        o = o_restore(); o.wv = 1'b1; o.wd = 32'hFFFF_FFFF; o.av = 1'b1; o.am = 32'hFFFF_FFFF;
        ops.push_back(o);
        foreach (ops[i]) begin
            applyStimulus(ops[i]);
            e = sb.pop_front();
            checks++;
            if ({eflags, stack_level, overflow_err, underflow_err, collision_err} !== {e.ef, e.lvl, e.ov, e.un, e.co})
                $display("[TB] FAIL collision op%0d: got ef=%h lvl=%0d err=%b%b%b, expected ef=%h lvl=%0d err=%b%b%b",
                         i, eflags, stack_level, overflow_err, underflow_err, collision_err, e.ef, e.lvl, e.ov, e.un, e.co);
            else passes++;
            if (i == 0) begin
                checks++;
                if ({eflags, cf, zf, collision_err} !== {32'h3, 1'b1, 1'b0, 1'b1})
                    $display("[TB] FAIL collision_bit_alu: got ef=%h coll=%b, expected ef=00000003 coll=1", eflags, collision_err);
                else passes++;
            end
            if (i == 2) begin
                checks++;
                if (collision_err !== 1'b0)
                    $display("[TB] FAIL collision_pulse: got coll=%b, expected coll=0", collision_err);
                else passes++;
            end
        end
    endtask

    // Random mixes of requests every cycle, also checking the decoded flag outputs.
    task automatic test_back_to_back();
        op_t  o;
        exp_t e;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            o     = '0;
            o.sv  = ($urandom_range(0, 5) == 0);
            o.rv  = ($urandom_range(0, 5) == 0);
            o.wv  = ($urandom_range(0, 4) == 0);
            o.wd  = $urandom();
            o.cp  = 2'($urandom_range(0, 3));
            o.bv  = ($urandom_range(0, 2) == 0);
            o.bop = 2'($urandom_range(0, 3));
            o.bi  = 5'($urandom_range(0, 31));
            o.av  = ($urandom_range(0, 2) == 0);
            o.am  = $urandom();
            o.ad  = $urandom();
            applyStimulus(o);
            e = sb.pop_front();
            checks++;
            if ({eflags, stack_level, overflow_err, underflow_err, collision_err} !== {e.ef, e.lvl, e.ov, e.un, e.co})
                $display("[TB] FAIL random op%0d: got ef=%h lvl=%0d err=%b%b%b, expected ef=%h lvl=%0d err=%b%b%b",
                         i, eflags, stack_level, overflow_err, underflow_err, collision_err, e.ef, e.lvl, e.ov, e.un, e.co);
            else passes++;
            checks++;
            if ({flags, cf, pf, af, zf, sf, tf, if_flag, df, of_flag, iopl, nt, rf, vm, stack_empty, stack_full}
                !== {e.ef[15:0], e.ef[0], e.ef[2], e.ef[4], e.ef[6], e.ef[7], e.ef[8], e.ef[9], e.ef[10],
                     e.ef[11], e.ef[13:12], e.ef[14], e.ef[16], e.ef[17], (e.lvl == 3'd0), (e.lvl == 3'd4)})
                $display("[TB] FAIL decode op%0d: got flags=%h empty=%b full=%b, expected ef=%h lvl=%0d",
                         i, flags, stack_empty, stack_full, e.ef, e.lvl);
            else passes++;
        end
    endtask

    // Asynchronous reset mid-sequence must clear the register and the stack level.
    task automatic test_reset_mid();
        exp_t e;
        do_reset();
        applyStimulus(o_bit(2'b01, 5'd8));
        e = sb.pop_front();
        applyStimulus(o_save());
        e = sb.pop_front();
        applyStimulus(o_save());
        e = sb.pop_front();
        checks++;
        if (stack_level !== e.lvl)
            $display("[TB] FAIL pre_reset_level: got lvl=%0d, expected lvl=%0d", stack_level, e.lvl);
        else passes++;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({eflags, stack_level, stack_empty} !== {32'h2, 3'd0, 1'b1})
            $display("[TB] FAIL async_reset: got ef=%h lvl=%0d empty=%b, expected ef=00000002 lvl=0 empty=1",
                     eflags, stack_level, stack_empty);
        else passes++;
        @(posedge clock);
        #1;
        reset = 1'b0;
        m_ef = RV;
        m_stack.delete();
        applyStimulus(o_restore());
        e = sb.pop_front();
        checks++;
        if ({eflags, underflow_err} !== {32'h2, 1'b1})
            $display("[TB] FAIL restore_after_reset: got ef=%h un=%b, expected ef=00000002 un=1", eflags, underflow_err);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_write();
        test_bit();
        test_stack();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
